serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
Bit-serial two's-complement subtractor, the companion of the team's serial adder datapath. It computes DIFF = A - B one bit per clock, LSB first, as A + ~B + 1. It captures parallel operands on START and returns a parallel difference with borrow and signed-overflow flags. A one-cycle DONE pulse marks completion. It sits in the same arithmetic unit as the serial adder, under the same START/CLK/RST control style.

Parameters:
SIZE, 8, operand and difference width in bits (>= 2).

Ports:
CLK     input   1     clock, all state updates on rising edge
RST     input   1     reset, asynchronous, active-low
START   input   1     request; sampled only in IDLE
A       input   SIZE  minuend; captured when START is accepted
B       input   SIZE  subtrahend; captured when START is accepted
DIFF    output  SIZE  result A - B mod 2^SIZE; registered, holds until next completion
BORROW  output  1     1 when unsigned A < B (inverse of final carry); registered
OVF     output  1     signed overflow, carry-into-MSB XOR carry-out-of-MSB; registered
BUSY    output  1     1 while in SHIFT
DONE    output  1     one-cycle pulse when the result is first valid

Behaviour:
- Reset (RST=0, asynchronous): state=IDLE; DIFF=0, BORROW=0, OVF=0, BUSY=0, DONE=0; operand registers, shift register, carry FF and bit counter all cleared.
- States:
  - IDLE
  - SHIFT
  - DONE
- IDLE:
  - BUSY=0, DONE=0.
  - On an edge with START=1: load A and B into operand shift registers, preset carry FF to 1, clear bit counter, go to SHIFT.
  - START=0 keeps the block in IDLE.
- SHIFT (BUSY=1), on each edge:
  - Form a0 = A_reg[0] and nb0 = ~B_reg[0].
  - d = a0 ^ nb0 ^ c.
  - c <= (a0&nb0) | (a0&c) | (nb0&c).
  - Shift A_reg and B_reg right by 1.
  - Shift d into the MSB of the internal difference shift register.
  - Increment the counter.
- On the bit-(SIZE-1) edge (counter == SIZE-1):
  - Move the full difference to DIFF.
  - BORROW <= ~carry_out.
  - OVF <= c ^ carry_out, where c is the carry into the MSB.
  - Go to DONE.
- DONE:
  - DONE=1, BUSY=0 for exactly one cycle.
  - Next edge goes to IDLE unconditionally.
  - START is ignored in this state.
- Latency: START accepted at edge 0; bits are processed at edges 1..SIZE; DIFF/BORROW/OVF update and DONE is high in the cycle after edge SIZE. Back-to-back operations require a START at or after the edge that returns to IDLE, giving a minimum period of SIZE+2 cycles.
- START asserted while in SHIFT or DONE has no effect; there is no queueing.
- A and B changes after acceptance have no effect on the running operation.
- DIFF, BORROW and OVF keep the previous result during SHIFT and change only at completion.
- Reset mid-operation:
  - Immediate return to IDLE with all outputs cleared.
  - No DONE pulse.
  - The next START behaves exactly as after power-on.
- Bit counter width is clog2(SIZE)+1; it never wraps within an operation.

Test Plan:
- SIZE=8, A=100, B=37, START for 1 cycle -> BUSY high for 8 cycles; DONE pulse in cycle 9 after the accept edge; DIFF=0x3F, BORROW=0, OVF=0.
- A=0x05, B=0x09 -> DIFF=0xFC, BORROW=1, OVF=0. A=0xA5, B=0xA5 -> DIFF=0x00, BORROW=0, OVF=0.
- Overflow cases:
  - A=0x80, B=0x01 -> DIFF=0x7F, BORROW=0, OVF=1.
  - A=0x7F, B=0xFF -> DIFF=0x80, BORROW=1, OVF=1.
- Start A=0x10, B=0x01; during SHIFT, change A/B to 0xFF/0xFF and pulse START twice, including during DONE -> DIFF=0x0F, exactly one DONE pulse, no second operation.
- Start A=0x33, B=0x11; drive RST low at the 4th SHIFT cycle -> all outputs 0 immediately, no DONE. Release RST, then run A=0x33, B=0x11 -> DIFF=0x22 after 8 shift cycles.
- SIZE=4 instance, A=3, B=5 -> DIFF=0xE, BORROW=1, OVF=0; DONE 5 cycles after the accept edge.

Source files
------------

// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor.
// master drives the request side; slave is the subtractor itself.
interface serial_subtractor_if #(
  parameter int unsigned SIZE = 8
);
  logic            START;
  logic [SIZE-1:0] A;
  logic [SIZE-1:0] B;
  logic [SIZE-1:0] DIFF;
  logic            BORROW;
  logic            OVF;
  logic            BUSY;
  logic            DONE;

  modport master (
    output START, A, B,
    input  DIFF, BORROW, OVF, BUSY, DONE
  );

  modport slave (
    input  START, A, B,
    output DIFF, BORROW, OVF, BUSY, DONE
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: DIFF = A + ~B + 1, LSB first,
// one bit per clock, with borrow and signed-overflow flags and a DONE pulse.
module serial_subtractor #(
  parameter int unsigned SIZE = 8
) (
  input  logic               CLK,
  input  logic               RST,
  serial_subtractor_if.slave bus
);

  localparam int unsigned CW = $clog2(SIZE) + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [SIZE-1:0] a_sr, a_n;
  logic [SIZE-1:0] b_sr, b_n;
  logic [SIZE-1:0] d_sr, d_n;
  logic            c, c_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [SIZE-1:0] diff_q, diff_n;
  logic            borrow_q, borrow_n;
  logic            ovf_q, ovf_n;
  logic            busy_q, busy_n;
  logic            done_q, done_n;
  logic            a0, nb0, sum, cout;

  // State and datapath registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= ST_IDLE;
      a_sr     <= '0;
      b_sr     <= '0;
      d_sr     <= '0;
      c        <= 1'b0;
      cnt      <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_n;
      a_sr     <= a_n;
      b_sr     <= b_n;
      d_sr     <= d_n;
      c        <= c_n;
      cnt      <= cnt_n;
      diff_q   <= diff_n;
      borrow_q <= borrow_n;
      ovf_q    <= ovf_n;
      busy_q   <= busy_n;
      done_q   <= done_n;
    end
  end

  // Next-state and next-datapath logic; one full-adder slice per SHIFT edge
  always_comb begin
    state_n  = state;
    a_n      = a_sr;
    b_n      = b_sr;
    d_n      = d_sr;
    c_n      = c;
    cnt_n    = cnt;
    diff_n   = diff_q;
    borrow_n = borrow_q;
    ovf_n    = ovf_q;
    a0       = a_sr[0];
    nb0      = ~b_sr[0];
    sum      = a0 ^ nb0 ^ c;
    cout     = (a0 & nb0) | (a0 & c) | (nb0 & c);

    case (state)
      ST_IDLE: begin
        if (bus.START) begin
          a_n     = bus.A;
          b_n     = bus.B;
          c_n     = 1'b1;
          cnt_n   = '0;
          state_n = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        a_n   = a_sr >> 1;
        b_n   = b_sr >> 1;
        d_n   = {sum, d_sr[SIZE-1:1]};
        c_n   = cout;
        cnt_n = CW'(cnt + CW'(1));
        // c here is the carry into the MSB, cout the carry out of it
        if (cnt == CW'(SIZE - 1)) begin
          diff_n   = {sum, d_sr[SIZE-1:1]};
          borrow_n = ~cout;
          ovf_n    = c ^ cout;
          state_n  = ST_DONE;
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase

    busy_n = (state_n == ST_SHIFT);
    done_n = (state_n == ST_DONE);
  end

  assign bus.DIFF   = diff_q;
  assign bus.BORROW = borrow_q;
  assign bus.OVF    = ovf_q;
  assign bus.BUSY   = busy_q;
  assign bus.DONE   = done_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: SIZE=8 and SIZE=4 instances, directed and
// random operands checked against an integer-arithmetic reference.
module tb_serial_subtractor;

  logic CLK;
  logic RST;
  int   tests;
  int   fails;

  logic [9:0] prev8;
  logic [9:0] prev4;

  serial_subtractor_if #(.SIZE(8)) i8 ();
  serial_subtractor_if #(.SIZE(4)) i4 ();

  serial_subtractor #(.SIZE(8)) u8 (.CLK(CLK), .RST(RST), .bus(i8.slave));
  serial_subtractor #(.SIZE(4)) u4 (.CLK(CLK), .RST(RST), .bus(i4.slave));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {busy, done, borrow, ovf, diff(zero-extended to 8)}
  function automatic logic [11:0] snap(input int w);
    if (w == 8) return {i8.BUSY, i8.DONE, i8.BORROW, i8.OVF, i8.DIFF};
    else        return {i4.BUSY, i4.DONE, i4.BORROW, i4.OVF, 4'h0, i4.DIFF};
  endfunction

  task automatic drive(input int w, input logic st, input logic [7:0] a, input logic [7:0] b);
    if (w == 8) begin
      i8.START = st; i8.A = a; i8.B = b;
    end else begin
      i4.START = st; i4.A = a[3:0]; i4.B = b[3:0];
    end
  endtask

  // One full operation with latency and result checks against plain arithmetic
  task automatic run_op(input int w, input logic [7:0] a, input logic [7:0] b);
    int mask, ai, bi, ed, half, sa, sb, sr;
    logic eb, eo;
    logic [11:0] s;
    logic [9:0] pv;
    mask = (1 << w) - 1;
    ai   = int'(a) & mask;
    bi   = int'(b) & mask;
    ed   = (ai - bi) & mask;
    eb   = (ai < bi);
    half = 1 << (w - 1);
    sa   = (ai >= half) ? ai - (1 << w) : ai;
    sb   = (bi >= half) ? bi - (1 << w) : bi;
    sr   = sa - sb;
    eo   = (sr < -half) || (sr > half - 1);
    pv   = (w == 8) ? prev8 : prev4;

    @(negedge CLK);
    drive(w, 1'b1, a, b);
    @(posedge CLK); #1;
    drive(w, 1'b0, a, b);
    s = snap(w);
    check($sformatf("busy_after_accept w%0d", w), 32'(s[11]), 32'd1);
    check($sformatf("done_after_accept w%0d", w), 32'(s[10]), 32'd0);
    repeat (w - 1) @(posedge CLK);
    #1;
    s = snap(w);
    check($sformatf("busy_last_shift w%0d", w), 32'(s[11]), 32'd1);
    check($sformatf("hold_prev w%0d", w), 32'(s[9:0]), 32'(pv));
    @(posedge CLK); #1;
    s = snap(w);
    check($sformatf("done_pulse w%0d a=%0h b=%0h", w, a, b), 32'(s[11:10]), 32'b01);
    check($sformatf("diff w%0d a=%0h b=%0h", w, a, b), 32'(s[7:0]), 32'(ed));
    check($sformatf("borrow w%0d a=%0h b=%0h", w, a, b), 32'(s[9]), 32'(eb));
    check($sformatf("ovf w%0d a=%0h b=%0h", w, a, b), 32'(s[8]), 32'(eo));
    @(posedge CLK); #1;
    s = snap(w);
    check($sformatf("done_drop w%0d", w), 32'(s[11:10]), 32'b00);
    if (w == 8) prev8 = {eb, eo, 8'(ed)};
    else        prev4 = {eb, eo, 8'(ed)};
  endtask

  initial begin
    logic [11:0] s;
    int act;
    tests = 0;
    fails = 0;
    prev8 = '0;
    prev4 = '0;
    RST = 1'b0;
    drive(8, 1'b0, 8'h00, 8'h00);
    drive(4, 1'b0, 8'h00, 8'h00);
    #12;
    check("reset_w8", 32'(snap(8)), 32'd0);
    check("reset_w4", 32'(snap(4)), 32'd0);
    @(negedge CLK);
    RST = 1'b1;

    // Directed 8-bit cases
    run_op(8, 8'd100, 8'd37);
    run_op(8, 8'h05, 8'h09);
    run_op(8, 8'hA5, 8'hA5);
    run_op(8, 8'h80, 8'h01);
    run_op(8, 8'h7F, 8'hFF);

    // Operand changes and extra STARTs during SHIFT/DONE are ignored
    @(negedge CLK);
    drive(8, 1'b1, 8'h10, 8'h01);
    @(posedge CLK); #1;
    drive(8, 1'b0, 8'hFF, 8'hFF);
    repeat (3) @(posedge CLK);
    #1;
    i8.START = 1'b1;
    @(posedge CLK); #1;
    i8.START = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
    s = snap(8);
    check("ign_done", 32'(s[11:10]), 32'b01);
    check("ign_result", 32'(s[9:0]), 32'h00F);
    i8.START = 1'b1;
    @(posedge CLK); #1;
    i8.START = 1'b0;
    s = snap(8);
    check("ign_idle", 32'(s[11:10]), 32'b00);
    act = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge CLK); #1;
      if (i8.BUSY || i8.DONE) act++;
    end
    check("ign_no_second_op", 32'(act), 32'd0);
    prev8 = 10'h00F;

    // Asynchronous reset in the 4th SHIFT cycle
    @(negedge CLK);
    drive(8, 1'b1, 8'h33, 8'h11);
    @(posedge CLK); #1;
    drive(8, 1'b0, 8'h33, 8'h11);
    repeat (3) @(posedge CLK);
    #2;
    RST = 1'b0;
    #1;
    check("midreset_outputs", 32'(snap(8)), 32'd0);
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    act = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge CLK); #1;
      if (i8.BUSY || i8.DONE) act++;
    end
    check("midreset_no_done", 32'(act), 32'd0);
    prev8 = '0;
    prev4 = '0;
    run_op(8, 8'h33, 8'h11);

    // Random 8-bit operands
    for (int k = 0; k < 16; k++) begin
      run_op(8, 8'($urandom), 8'($urandom));
    end

    // SIZE=4 directed and random
    run_op(4, 8'd3, 8'd5);
    run_op(4, 8'h8, 8'h1);
    run_op(4, 8'h7, 8'hF);
    for (int k = 0; k < 8; k++) begin
      run_op(4, 8'($urandom_range(15, 0)), 8'($urandom_range(15, 0)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
